// File: rtl/matmul_irregular_stream.sv
// Streaming C = A(MxK) * B(KxN) with runtime dimensions up to MAX_*.
// Operands are buffered in register arrays; C is produced one element per K+1 cycles.
module matmul_irregular_stream #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int MAX_M  = 8,
    parameter int MAX_K  = 8,
    parameter int MAX_N  = 8,
    parameter int DIM_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  dim_m,
    input  logic [DIM_W-1:0]  dim_k,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int MI_W = (MAX_M > 1) ? $clog2(MAX_M) : 1;
    localparam int KI_W = (MAX_K > 1) ? $clog2(MAX_K) : 1;
    localparam int NI_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [DIM_W-1:0] MAX_M_D = DIM_W'(MAX_M);
    localparam logic [DIM_W-1:0] MAX_K_D = DIM_W'(MAX_K);
    localparam logic [DIM_W-1:0] MAX_N_D = DIM_W'(MAX_N);
    localparam logic [DIM_W-1:0] ONE     = DIM_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_MAC,
        S_OUT
    } state_t;

    state_t state, state_nx;

    logic [DIM_W-1:0] m_r, k_r, n_r;
    logic [DIM_W-1:0] row_r, col_r;
    logic [DIM_W-1:0] i_r, j_r, kk_r;
    logic [ACC_W-1:0] acc_r;

    logic [DATA_W-1:0] a_mem [MAX_M][MAX_K];
    logic [DATA_W-1:0] b_mem [MAX_K][MAX_N];

    logic                cfg_ok;
    logic                in_fire;
    logic                load_col_end, load_row_end;
    logic                k_last, i_last, j_last;
    logic [DATA_W-1:0]   a_op, b_op;
    logic [2*DATA_W-1:0] a_ext, b_ext, prod;
    logic [ACC_W-1:0]    sum;

    assign cfg_ok = (dim_m != '0) && (dim_k != '0) && (dim_n != '0) &&
                    (dim_m <= MAX_M_D) && (dim_k <= MAX_K_D) && (dim_n <= MAX_N_D);
    assign in_fire = in_valid && in_ready;

    // The same row/col counters walk A (M x K) and then B (K x N).
    always_comb begin
        load_col_end = 1'b0;
        load_row_end = 1'b0;
        if (state == S_LOAD_A) begin
            load_col_end = (col_r == k_r - ONE);
            load_row_end = (row_r == m_r - ONE);
        end else begin
            load_col_end = (col_r == n_r - ONE);
            load_row_end = (row_r == k_r - ONE);
        end
    end

    assign k_last = (kk_r == k_r - ONE);
    assign i_last = (i_r == m_r - ONE);
    assign j_last = (j_r == n_r - ONE);

    always_comb begin
        a_op  = a_mem[i_r[MI_W-1:0]][kk_r[KI_W-1:0]];
        b_op  = b_mem[kk_r[KI_W-1:0]][j_r[NI_W-1:0]];
        a_ext = {{DATA_W{a_op[DATA_W-1]}}, a_op};
        b_ext = {{DATA_W{b_op[DATA_W-1]}}, b_op};
        prod  = a_ext * b_ext;
        sum   = ((kk_r == '0) ? '0 : acc_r) +
                {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start && cfg_ok) state_nx = S_LOAD_A;
            end
            S_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && load_col_end && load_row_end) state_nx = S_LOAD_B;
            end
            S_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && load_col_end && load_row_end) state_nx = S_MAC;
            end
            S_MAC: begin
                if (k_last) state_nx = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = (i_last && j_last) ? S_IDLE : S_MAC;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            if (state == S_LOAD_A) a_mem[row_r[MI_W-1:0]][col_r[KI_W-1:0]] <= in_data;
            else                   b_mem[row_r[KI_W-1:0]][col_r[NI_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r      <= '0;
            k_r      <= '0;
            n_r      <= '0;
            row_r    <= '0;
            col_r    <= '0;
            i_r      <= '0;
            j_r      <= '0;
            kk_r     <= '0;
            acc_r    <= '0;
            out_data <= '0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            m_r   <= dim_m;
                            k_r   <= dim_k;
                            n_r   <= dim_n;
                            row_r <= '0;
                            col_r <= '0;
                            i_r   <= '0;
                            j_r   <= '0;
                            kk_r  <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (in_fire) begin
                        if (load_col_end) begin
                            col_r <= '0;
                            row_r <= load_row_end ? '0 : row_r + ONE;
                        end else begin
                            col_r <= col_r + ONE;
                        end
                    end
                end
                S_MAC: begin
                    acc_r <= sum;
                    if (k_last) begin
                        kk_r     <= '0;
                        out_data <= sum;
                    end else begin
                        kk_r <= kk_r + ONE;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (i_last && j_last) begin
                            done <= 1'b1;
                        end else if (j_last) begin
                            j_r <= '0;
                            i_r <= i_r + ONE;
                        end else begin
                            j_r <= j_r + ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_irregular_stream.sv
// Bench for matmul_irregular_stream: table of jobs plus hand-written config-error
// and mid-job reset sequences; C elements are checked from a scoreboard queue.
module tb_matmul_irregular_stream;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;
    localparam int MAX_M  = 8;
    localparam int MAX_K  = 8;
    localparam int MAX_N  = 8;
    localparam int DIM_W  = 4;

    typedef logic [15:0][31:0] arr16_t;
    typedef struct packed {
        int     m;
        int     k;
        int     n;
        int     gaps;
        int     stall;
        arr16_t a;
        arr16_t b;
        arr16_t c;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [DIM_W-1:0]  dim_m = '0, dim_k = '0, dim_n = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_data;
    logic              busy, done, cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    int job_m, job_k, job_n, job_gaps, job_stall;
    int ja[64];
    int jb[64];
    logic [ACC_W-1:0] exp_q[$];
    vec_t tbl[7];

    matmul_irregular_stream #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_M(MAX_M),
        .MAX_K(MAX_K), .MAX_N(MAX_N), .DIM_W(DIM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [ACC_W-1:0] to_acc(input longint v);
        return v[ACC_W-1:0];
    endfunction

    function automatic arr16_t pk16(input int e0 = 0, input int e1 = 0, input int e2 = 0,
                                    input int e3 = 0, input int e4 = 0, input int e5 = 0,
                                    input int e6 = 0, input int e7 = 0, input int e8 = 0,
                                    input int e9 = 0, input int e10 = 0, input int e11 = 0,
                                    input int e12 = 0, input int e13 = 0, input int e14 = 0,
                                    input int e15 = 0);
        arr16_t r;
        r[0] = e0;   r[1] = e1;   r[2] = e2;   r[3] = e3;
        r[4] = e4;   r[5] = e5;   r[6] = e6;   r[7] = e7;
        r[8] = e8;   r[9] = e9;   r[10] = e10; r[11] = e11;
        r[12] = e12; r[13] = e13; r[14] = e14; r[15] = e15;
        return r;
    endfunction

    // Feeds A then B; positioned just after a negedge on entry and exit.
    task automatic loader();
        int total = job_m * job_k + job_k * job_n;
        int idx = 0;
        int budget = 0;
        bit ph = 1'b0;
        int v;
        while (idx < total && budget < 2000) begin
            if (job_gaps != 0 && ph) begin
                in_valid = 1'b0;
            end else begin
                v = (idx < job_m * job_k) ? ja[idx] : jb[idx - job_m * job_k];
                in_valid = 1'b1;
                in_data  = DATA_W'(v);
                if (in_ready) idx++;
            end
            ph = ~ph;
            @(negedge clk);
            budget++;
        end
        if (idx < total) check("load_timeout", 64'(idx), 64'(total));
        check("in_ready_after_load", 64'(in_ready), 64'd0);
        // Junk data and an illegal start while busy must both be ignored.
        in_valid = 1'b1;
        in_data  = 16'h7fff;
        start    = 1'b1;
        dim_m    = '0;
        @(negedge clk);
        start    = 1'b0;
        check("start_ignored_busy", 64'(cfg_err), 64'd0);
        check("busy_during_job", 64'(busy), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic consumer();
        int total = job_m * job_n;
        int got = 0;
        int budget = 0;
        int cnt = 0;
        int since = 0;
        bit early_done = 1'b0;
        logic [ACC_W-1:0] held = '0;
        logic [ACC_W-1:0] exp_v;
        while (got < total && budget < 4000) begin
            if (done) early_done = 1'b1;
            if (out_valid) begin
                if (cnt == 0) held = out_data;
                else check("stall_stable", 64'(out_data), 64'(held));
                if (cnt < job_stall) begin
                    out_ready = 1'b0;
                    cnt++;
                end else begin
                    out_ready = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("scoreboard_underflow", 64'd1, 64'd0);
                        exp_v = '0;
                    end else begin
                        exp_v = exp_q.pop_front();
                    end
                    check("c_elem", 64'(out_data), 64'(exp_v));
                    if (job_stall == 0 && got > 0) check("elem_gap", 64'(since), 64'(job_k + 1));
                    since = 0;
                    got++;
                    cnt = 0;
                end
            end else begin
                out_ready = (job_stall == 0);
            end
            @(negedge clk);
            budget++;
            since++;
        end
        if (got < total) check("out_timeout", 64'(got), 64'(total));
        check("no_early_done", 64'(early_done), 64'd0);
        check("done_pulse", 64'(done), 64'd1);
        check("idle_after_done", 64'(busy), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_job();
        start = 1'b1;
        dim_m = DIM_W'(job_m);
        dim_k = DIM_W'(job_k);
        dim_n = DIM_W'(job_n);
        @(negedge clk);
        start = 1'b0;
        fork
            loader();
            consumer();
        join
    endtask

    task automatic run_vec(input vec_t v);
        int av, bv, cv;
        job_m = v.m; job_k = v.k; job_n = v.n;
        job_gaps = v.gaps; job_stall = v.stall;
        for (int i = 0; i < 16; i++) begin
            av = v.a[i]; bv = v.b[i];
            ja[i] = av;  jb[i] = bv;
        end
        for (int i = 0; i < v.m * v.n; i++) begin
            cv = v.c[i];
            exp_q.push_back(to_acc(longint'(cv)));
        end
        run_job();
    endtask

    task automatic cfg_err_case(input int m, input int k, input int n);
        start = 1'b1;
        dim_m = DIM_W'(m); dim_k = DIM_W'(k); dim_n = DIM_W'(n);
        @(negedge clk);
        start = 1'b0;
        check("cfg_err_pulse", 64'(cfg_err), 64'd1);
        check("cfg_err_busy", 64'(busy), 64'd0);
        check("cfg_err_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("cfg_err_clear", 64'(cfg_err), 64'd0);
        check("cfg_err_still_idle", 64'(busy), 64'd0);
    endtask

    task automatic wait_out_valid(input string nm);
        int b = 0;
        while (!out_valid && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (!out_valid) check(nm, 64'd0, 64'd1);
    endtask

    initial begin
        longint s;
        tbl[0] = '{2, 3, 2, 0, 0, pk16(1, 2, 3, 4, 5, 6), pk16(7, 8, 9, 10, 11, 12),
                   pk16(58, 64, 139, 154)};
        tbl[1] = '{1, 4, 1, 0, 0, pk16(-1, 2, -3, 4), pk16(5, 6, 7, 8), pk16(18)};
        tbl[2] = '{1, 1, 1, 0, 0, pk16(-32768), pk16(-32768), pk16(1073741824)};
        tbl[3] = '{2, 3, 2, 0, 5, pk16(1, 2, 3, 4, 5, 6), pk16(7, 8, 9, 10, 11, 12),
                   pk16(58, 64, 139, 154)};
        tbl[4] = '{2, 3, 2, 1, 0, pk16(1, 2, 3, 4, 5, 6), pk16(7, 8, 9, 10, 11, 12),
                   pk16(58, 64, 139, 154)};
        tbl[5] = '{3, 1, 2, 1, 2, pk16(1, 2, -3), pk16(4, 5), pk16(4, 5, 8, 10, -12, -15)};
        tbl[6] = '{2, 2, 2, 0, 0, pk16(1, 0, 0, 1), pk16(3, 4, 5, 6), pk16(3, 4, 5, 6)};

        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        cfg_err_case(2, 0, 2);
        cfg_err_case(2, 2, MAX_N + 1);

        for (int t = 0; t < 6; t++) run_vec(tbl[t]);

        // Full-size job with random operands against a reference product.
        job_m = MAX_M; job_k = MAX_K; job_n = MAX_N; job_gaps = 1; job_stall = 0;
        for (int i = 0; i < 64; i++) begin
            ja[i] = $signed(16'($urandom));
            jb[i] = $signed(16'($urandom));
        end
        for (int r = 0; r < MAX_M; r++)
            for (int c = 0; c < MAX_N; c++) begin
                s = 0;
                for (int x = 0; x < MAX_K; x++)
                    s += longint'(ja[r * MAX_K + x]) * longint'(jb[x * MAX_N + c]);
                exp_q.push_back(to_acc(s));
            end
        run_job();

        // Mid-job reset while element (0,1) is waiting in OUT.
        job_m = 2; job_k = 3; job_n = 2; job_gaps = 0; job_stall = 0;
        for (int i = 0; i < 6; i++) begin
            ja[i] = i + 1;
            jb[i] = i + 7;
        end
        out_ready = 1'b0;
        start = 1'b1;
        dim_m = 4'd2; dim_k = 4'd3; dim_n = 4'd2;
        @(negedge clk);
        start = 1'b0;
        loader();
        wait_out_valid("rst_job_first_timeout");
        check("rst_job_c00", 64'(out_data), 64'd58);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        wait_out_valid("rst_job_second_timeout");
        check("rst_job_c01", 64'(out_data), 64'd64);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_no_done", 64'(done), 64'd0);
        run_vec(tbl[6]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
